ps_comp_unit: RTL and testbench



---
 rtl/ps_comp_unit.sv | 81 ++++++++
 tb/tb_ps_comp_unit.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/ps_comp_unit.sv
// Per-window signal energy estimator: sums din^2 over window_len accepted samples
// and emits the saturated total with a one-cycle data_valid strobe.
module ps_comp_unit #(
    parameter int input_width  = 16,
    parameter int output_width = 32,
    parameter int window_len   = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic signed [input_width-1:0]  din,
    input  logic                           en,
    output logic [output_width-1:0]        dout,
    output logic                           data_valid
);

    localparam int sq_width  = 2 * input_width;
    localparam int acc_width = sq_width + $clog2(window_len + 1);
    localparam int cnt_width = (window_len > 1) ? $clog2(window_len) : 1;
    localparam int cmp_width = (acc_width > output_width) ? acc_width : output_width + 1;
    localparam logic [cnt_width-1:0] last_count = cnt_width'(window_len - 1);

    logic signed [sq_width-1:0]  din_ext;
    logic signed [sq_width-1:0]  sq_prod;
    logic [sq_width-1:0]         sq;
    logic                        sq_v;
    logic [acc_width-1:0]        acc;
    logic [acc_width-1:0]        acc_sum;
    logic [cmp_width-1:0]        sum_ext;
    logic [output_width-1:0]     dout_next;
    logic [cnt_width-1:0]        count;

    // Sign-extend before multiplying so the most negative input squares exactly.
    assign din_ext = {{input_width{din[input_width-1]}}, din};
    assign sq_prod = din_ext * din_ext;

    assign acc_sum = acc + acc_width'(sq);

    always_comb begin
        sum_ext   = cmp_width'(acc_sum);
        dout_next = sum_ext[output_width-1:0];
        if (|sum_ext[cmp_width-1:output_width]) begin
            dout_next = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sq   <= '0;
            sq_v <= 1'b0;
        end else begin
            sq_v <= en;
            if (en) begin
                sq <= sq_prod;
            end
        end
    end

    // The last square of a window bypasses the accumulator straight into dout.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            count      <= '0;
            dout       <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (sq_v) begin
                if (count == last_count) begin
                    dout       <= dout_next;
                    data_valid <= 1'b1;
                    acc        <= '0;
                    count      <= '0;
                end else begin
                    acc   <= acc_sum;
                    count <= count + cnt_width'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ps_comp_unit.sv
// Directed self-checking bench for ps_comp_unit with the default 16-sample window.
module tb_ps_comp_unit;

    logic               test_clk = 1'b0;
    logic               rst;
    logic signed [15:0] din;
    logic               en;
    logic [31:0]        dout;
    logic               data_valid;

    int assertions_evaluated = 0;
    int failures = 0;
    int pulse_count = 0;
    int cycle = 0;
    int pulse_cycle[$];
    logic [31:0] pulse_dout[$];

    ps_comp_unit #(.input_width(16), .output_width(32), .window_len(16)) dut (
        .clk(test_clk),
        .rst(rst),
        .din(din),
        .en(en),
        .dout(dout),
        .data_valid(data_valid)
    );

    always #5 test_clk = ~test_clk;

    // Records every strobe with its cycle number and the value it published.
    always @(posedge test_clk) begin
        #1;
        cycle++;
        if (data_valid === 1'b1) begin
            pulse_count++;
            pulse_cycle.push_back(cycle);
            pulse_dout.push_back(dout);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertions_evaluated++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed %0d (0x%h), expected %0d (0x%h)", tag, observed, observed, expected, expected);
        end
    endtask

    task automatic applyStimulus(input logic e, input logic signed [15:0] d);
        @(negedge test_clk);
        en  = e;
        din = d;
    endtask

    task automatic pulseReset();
        @(negedge test_clk);
        rst = 1'b1;
        en  = 1'b0;
        @(negedge test_clk);
        rst = 1'b0;
    endtask

    task automatic feedWindow(input logic signed [15:0] v);
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, v);
    endtask

    // Called right after the 16th accepted sample has been driven.
    task automatic expectResult(input string tag, input logic [31:0] expected);
        int base;
        base = pulse_count;
        applyStimulus(1'b0, 16'sd0);
        checkOutput({tag, "_dv_early"}, {31'd0, data_valid}, 32'd0);
        applyStimulus(1'b0, 16'sd0);
        checkOutput({tag, "_dv"}, {31'd0, data_valid}, 32'd1);
        checkOutput({tag, "_dout"}, dout, expected);
        applyStimulus(1'b0, 16'sd0);
        checkOutput({tag, "_dv_low"}, {31'd0, data_valid}, 32'd0);
        checkOutput({tag, "_hold"}, dout, expected);
        checkOutput({tag, "_pulses"}, 32'(pulse_count - base), 32'd1);
    endtask

    initial begin
        int base;
        int qbase;
        rst = 1'b1;
        en  = 1'b0;
        din = '0;

        // Test 1: reset, then idle input with en low.
        pulseReset();
        checkOutput("reset_dout", dout, 32'd0);
        checkOutput("reset_dv", {31'd0, data_valid}, 32'd0);
        base = pulse_count;
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 16'($signed($urandom_range(0, 198)) - 99));
        applyStimulus(1'b0, 16'sd0);
        checkOutput("idle_pulses", 32'(pulse_count - base), 32'd0);
        checkOutput("idle_dout", dout, 32'd0);

        // Test 2: 16 x 100.
        feedWindow(16'sd100);
        expectResult("w100", 32'd160000);

        // Test 3: -3 with en gaps carrying junk data.
        base = pulse_count;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, -16'sd3);
            applyStimulus(1'b0, 16'sd5000);
            checkOutput("gap_no_early_pulse", 32'(pulse_count - base), 32'd0);
        end
        applyStimulus(1'b0, 16'sd5000);
        checkOutput("gap_dv", {31'd0, data_valid}, 32'd1);
        checkOutput("gap_dout", dout, 32'd144);
        applyStimulus(1'b0, 16'sd0);
        checkOutput("gap_dv_low", {31'd0, data_valid}, 32'd0);
        checkOutput("gap_pulses", 32'(pulse_count - base), 32'd1);

        // Test 4: saturation, then clean accumulator.
        feedWindow(-16'sd32768);
        expectResult("sat", 32'hFFFF_FFFF);
        feedWindow(16'sd1);
        expectResult("after_sat", 32'd16);

        // Test 5: partial window discarded by reset.
        base = pulse_count;
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 16'sd100);
        pulseReset();
        applyStimulus(1'b0, 16'sd0);
        checkOutput("partial_pulses", 32'(pulse_count - base), 32'd0);
        checkOutput("partial_reset_dout", dout, 32'd0);
        feedWindow(16'sd2);
        expectResult("post_reset", 32'd64);

        // Test 6: three back-to-back windows.
        qbase = pulse_cycle.size();
        for (int n = 0; n < 3; n++) feedWindow(16'(n + 1));
        applyStimulus(1'b0, 16'sd0);
        applyStimulus(1'b0, 16'sd0);
        applyStimulus(1'b0, 16'sd0);
        checkOutput("b2b_count", 32'(pulse_cycle.size() - qbase), 32'd3);
        if (pulse_cycle.size() - qbase == 3) begin
            checkOutput("b2b_dout0", pulse_dout[qbase], 32'd16);
            checkOutput("b2b_dout1", pulse_dout[qbase + 1], 32'd64);
            checkOutput("b2b_dout2", pulse_dout[qbase + 2], 32'd144);
            checkOutput("b2b_gap01", 32'(pulse_cycle[qbase + 1] - pulse_cycle[qbase]), 32'd16);
            checkOutput("b2b_gap12", 32'(pulse_cycle[qbase + 2] - pulse_cycle[qbase + 1]), 32'd16);
        end
        checkOutput("b2b_hold", dout, 32'd144);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions_evaluated, failures);
        $finish;
    end

endmodule
